// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 bit mux: steps select 0..3 with a settle
// window per channel and hands the assembled 4-bit word downstream.
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mux_out,
  output logic [1:0] select,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE out of range");
  end

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] asm_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      asm_r  <= 4'd0;
      select <= 2'd0;
      data   <= 4'd0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= SCAN;
            busy   <= 1'b1;
            select <= 2'd0;
            cnt    <= RELOAD;
            asm_r  <= 4'd0;
          end
        end
        SCAN: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            asm_r[select] <= mux_out;
            if (select != 2'd3) begin
              select <= select + 2'd1;
              cnt    <= RELOAD;
            end else begin
              // channel 3 goes straight into data; asm_r holds 0..2
              data   <= {mux_out, asm_r[2:0]};
              select <= 2'd0;
              state  <= DONE;
              valid  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ready) begin
            valid <= 1'b0;
            if (start) begin
              state <= SCAN;
              cnt   <= RELOAD;
              asm_r <= 4'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          select <= 2'd0;
          valid  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scans on SETTLE=1 and SETTLE=3
// instances, words checked by a queue-based scoreboard monitor.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, ready1, mux1, valid1, busy1;
  logic [1:0] sel1;
  logic [3:0] data1;
  logic       start3, ready3, mux3, valid3, busy3;
  logic [1:0] sel3;
  logic [3:0] data3;
  logic [3:0] chv1, chv3;
  logic       frc3;

  int tests = 0;
  int fails = 0;
  logic [3:0] q1[$];
  logic [3:0] q3[$];

  always #5 clk = ~clk;

  assign mux1 = chv1[sel1];
  assign mux3 = frc3 ? 1'b0 : chv3[sel3];

  mux_scan_ctrl #(.SETTLE(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .mux_out(mux1),
    .select(sel1), .data(data1), .valid(valid1), .ready(ready1),
    .busy(busy1)
  );

  mux_scan_ctrl #(.SETTLE(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .mux_out(mux3),
    .select(sel3), .data(data3), .valid(valid3), .ready(ready3),
    .busy(busy3)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // transfers happen at the next rising edge; sample half a cycle early
  always @(negedge clk) begin
    if (!reset && valid1 && ready1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL word1: got %0h expected none", data1);
      end else begin
        chk("word1", 32'(data1), 32'(q1.pop_front()));
      end
    end
    if (!reset && valid3 && ready3) begin
      if (q3.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL word3: got %0h expected none", data3);
      end else begin
        chk("word3", 32'(data3), 32'(q3.pop_front()));
      end
    end
  end

  task automatic scan1(input logic [3:0] w);
    chv1 = w;
    q1.push_back(w);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (4) step();
    chk("scan1_valid", 32'(valid1), 32'd1);
  endtask

  task automatic drain1();
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    chk("drain_valid", 32'(valid1), 32'd0);
    chk("drain_busy", 32'(busy1), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start1 = 1'b1;
    start3 = 1'b1;
    ready1 = 1'b0;
    ready3 = 1'b0;
    chv1   = 4'd0;
    chv3   = 4'd0;
    frc3   = 1'b0;

    // reset with start held high, then idle
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        reset  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
      end
      step();
      chk("rst_sel", 32'(sel1), 32'd0);
      chk("rst_data", 32'(data1), 32'd0);
      chk("rst_valid", 32'(valid1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
    end
    chk("rst_busy3", 32'(busy3), 32'd0);

    // single scan, SETTLE=1, channels (1,0,1,1)
    chv1 = 4'b1101;
    q1.push_back(4'b1101);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("s1_busy", 32'(busy1), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("s1_sel", 32'(sel1), 32'(k));
      chk("s1_nvalid", 32'(valid1), 32'd0);
      step();
    end
    chk("s1_valid", 32'(valid1), 32'd1);
    chk("s1_data", 32'(data1), 32'hd);
    chk("s1_selz", 32'(sel1), 32'd0);
    drain1();

    // SETTLE=3, channels (0,1,1,0), ch1 low early in its window
    chv3 = 4'b0110;
    q3.push_back(4'b0110);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("s3_sel", 32'(sel3), 32'(i / 3));
      chk("s3_nvalid", 32'(valid3), 32'd0);
      frc3 = (i == 3 || i == 4);
      step();
    end
    frc3 = 1'b0;
    chk("s3_valid", 32'(valid3), 32'd1);
    chk("s3_data", 32'(data3), 32'h6);
    ready3 = 1'b1;
    step();
    ready3 = 1'b0;
    chk("s3_done", 32'(busy3), 32'd0);

    // backpressure: word held, start and mux_out ignored
    scan1(4'b1010);
    for (int i = 0; i < 10; i++) begin
      start1 = i[0];
      chv1   = 4'(i * 7);
      step();
      chk("bp_valid", 32'(valid1), 32'd1);
      chk("bp_data", 32'(data1), 32'ha);
      chk("bp_sel", 32'(sel1), 32'd0);
    end
    start1 = 1'b0;
    drain1();

    // back-to-back restart from DONE
    scan1(4'b0011);
    chv1 = 4'b1100;
    q1.push_back(4'b1100);
    ready1 = 1'b1;
    start1 = 1'b1;
    step();
    ready1 = 1'b0;
    start1 = 1'b0;
    chk("b2b_busy", 32'(busy1), 32'd1);
    chk("b2b_sel", 32'(sel1), 32'd0);
    chk("b2b_valid", 32'(valid1), 32'd0);
    repeat (3) step();
    chk("b2b_early", 32'(valid1), 32'd0);
    step();
    chk("b2b_valid2", 32'(valid1), 32'd1);
    chk("b2b_data2", 32'(data1), 32'hc);
    drain1();

    // reset in the middle of a scan
    scan1(4'b1111);
    drain1();
    chv1 = 4'b0000;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    step();
    chk("mr_sel2", 32'(sel1), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_valid", 32'(valid1), 32'd0);
    chk("mr_busy", 32'(busy1), 32'd0);
    chk("mr_data", 32'(data1), 32'd0);
    chk("mr_sel", 32'(sel1), 32'd0);
    step();
    chk("mr_idle", 32'(busy1), 32'd0);
    scan1(4'b0101);
    chk("mr_word", 32'(data1), 32'h5);
    drain1();

    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q3_empty", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
